// File: rtl/atri_readout_sequencer_if.sv
// Bus bundle for atri_readout_sequencer: control handshake, instruction ROM port,
// event inputs and datapath write port.
interface atri_readout_sequencer_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  rom_addr;
    logic [17:0] rom_data;
    logic [7:0]  ev;
    logic [5:0]  port_id;
    logic [7:0]  port_data;
    logic        port_wr;
    logic [9:0]  pc;

    modport master (
        input  start, abort, rom_data, ev,
        output busy, done, error, rom_addr, port_id, port_data, port_wr, pc
    );

    modport slave (
        output start, abort, rom_data, ev,
        input  busy, done, error, rom_addr, port_id, port_data, port_wr, pc
    );
endinterface

// File: rtl/atri_readout_sequencer.sv
// ATRI readout micro-sequencer: fetches 18-bit instructions from the readout ROM and executes them.
// Optional WAIT timeout enabled by defining ATRI_SEQ_WAIT_TIMEOUT_EN.
module atri_readout_sequencer #(
    parameter int unsigned START_ADDR   = 0,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned WAIT_TIMEOUT = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    atri_readout_sequencer_if.master    bus
);
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = $clog2(STACK_DEPTH);

    if (STACK_DEPTH < 2 || STACK_DEPTH > 8 || WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 65535) begin : g_param_check
        $error("atri_readout_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DELAY, S_WAIT} state_t;

    state_t          state;
    logic [9:0]      pc_r;
    logic [SPW-1:0]  sp;
    logic [9:0]      stack [STACK_DEPTH];
    logic [13:0]     loop_cnt;
    logic [13:0]     dly_cnt;
    logic [2:0]      wait_sel;
    logic            wait_pol;
    logic            busy_r, done_r, error_r, port_wr_r;
    logic [5:0]      port_id_r;
    logic [7:0]      port_data_r;
`ifdef ATRI_SEQ_WAIT_TIMEOUT_EN
    logic [15:0]     tmo_cnt;
`endif

    logic [3:0]      opcode;
    logic [9:0]      pc_inc;
    logic [9:0]      target;
    logic [13:0]     cnt_dec;
    logic [SPW-1:0]  sp_inc;
    logic [SPW-1:0]  sp_dec;
    logic            ev_hit_exec;
    logic            ev_hit_wait;

    assign opcode      = bus.rom_data[17:14];
    assign target      = bus.rom_data[9:0];
    assign pc_inc      = pc_r + 10'd1;
    assign cnt_dec     = loop_cnt - 14'd1;
    assign sp_inc      = sp + SPW'(1);
    assign sp_dec      = sp - SPW'(1);
    assign ev_hit_exec = (bus.ev[bus.rom_data[2:0]] == bus.rom_data[3]);
    assign ev_hit_wait = (bus.ev[wait_sel] == wait_pol);

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;
    assign bus.port_wr   = port_wr_r;
    assign bus.port_id   = port_id_r;
    assign bus.port_data = port_data_r;
    assign bus.pc        = pc_r;
    assign bus.rom_addr  = pc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc_r        <= 10'(START_ADDR);
            sp          <= '0;
            loop_cnt    <= '0;
            dly_cnt     <= '0;
            wait_sel    <= '0;
            wait_pol    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            port_wr_r   <= 1'b0;
            port_id_r   <= '0;
            port_data_r <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
`ifdef ATRI_SEQ_WAIT_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            done_r    <= 1'b0;
            port_wr_r <= 1'b0;
            // Abort outranks everything, including the instruction currently in EXEC.
            if (state != S_IDLE && bus.abort) begin
                state       <= S_IDLE;
                busy_r      <= 1'b0;
                pc_r        <= 10'(START_ADDR);
                sp          <= '0;
                loop_cnt    <= '0;
                port_id_r   <= '0;
                port_data_r <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            pc_r    <= 10'(START_ADDR);
                            sp      <= '0;
                            error_r <= 1'b0;
                            busy_r  <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_EXEC;
                    S_EXEC: begin
                        state <= S_FETCH;
                        case (opcode)
                            4'd0: pc_r <= pc_inc;
                            4'd1: begin
                                port_id_r   <= bus.rom_data[13:8];
                                port_data_r <= bus.rom_data[7:0];
                                port_wr_r   <= 1'b1;
                                pc_r        <= pc_inc;
                            end
                            4'd2: begin
                                if (ev_hit_exec) begin
                                    pc_r <= pc_inc;
                                end else begin
                                    wait_sel <= bus.rom_data[2:0];
                                    wait_pol <= bus.rom_data[3];
                                    state    <= S_WAIT;
`ifdef ATRI_SEQ_WAIT_TIMEOUT_EN
                                    tmo_cnt  <= '0;
`endif
                                end
                            end
                            4'd3: begin
                                if (bus.rom_data[13:0] == 14'd0) begin
                                    pc_r <= pc_inc;
                                end else begin
                                    dly_cnt <= bus.rom_data[13:0];
                                    state   <= S_DELAY;
                                end
                            end
                            4'd4: pc_r <= target;
                            4'd5: begin
                                if (sp == SPW'(STACK_DEPTH)) begin
                                    error_r <= 1'b1;
                                    busy_r  <= 1'b0;
                                    state   <= S_IDLE;
                                end else begin
                                    stack[sp[IW-1:0]] <= pc_inc;
                                    sp                <= sp_inc;
                                    pc_r              <= target;
                                end
                            end
                            4'd6: begin
                                if (sp == '0) begin
                                    error_r <= 1'b1;
                                    busy_r  <= 1'b0;
                                    state   <= S_IDLE;
                                end else begin
                                    pc_r <= stack[sp_dec[IW-1:0]];
                                    sp   <= sp_dec;
                                end
                            end
                            4'd7: begin
                                loop_cnt <= bus.rom_data[13:0];
                                pc_r     <= pc_inc;
                            end
                            4'd8: begin
                                loop_cnt <= cnt_dec;
                                pc_r     <= (cnt_dec != 14'd0) ? target : pc_inc;
                            end
                            4'd9: begin
                                done_r <= 1'b1;
                                busy_r <= 1'b0;
                                state  <= S_IDLE;
                            end
                            default: begin
                                error_r <= 1'b1;
                                busy_r  <= 1'b0;
                                state   <= S_IDLE;
                            end
                        endcase
                    end
                    S_DELAY: begin
                        if (dly_cnt == 14'd1) begin
                            pc_r  <= pc_inc;
                            state <= S_FETCH;
                        end else begin
                            dly_cnt <= dly_cnt - 14'd1;
                        end
                    end
                    S_WAIT: begin
                        if (ev_hit_wait) begin
                            pc_r  <= pc_inc;
                            state <= S_FETCH;
                        end
`ifdef ATRI_SEQ_WAIT_TIMEOUT_EN
                        else if (tmo_cnt == 16'(WAIT_TIMEOUT - 1)) begin
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
`endif
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/atri_readout_sequencer.md
Name: atri_readout_sequencer

Overview:
Micro-sequencer that fetches and executes 18-bit readout instructions from the 1024-word ATRI readout instruction ROM.
- Drives the ROM address and consumes ROM data with 1-cycle read latency.
- Issues register-write strobes to the readout datapath.
- Sequences waits on external events, timed delays, loops and subroutine calls.
- Started by a trigger-side controller; reports busy/done/error.

Parameters:
START_ADDR, 0, ROM address loaded into the PC on start.
STACK_DEPTH, 4, call/return stack entries (2..8).
WAIT_TIMEOUT, 65535, cycles before a WAIT aborts (optional feature only).

Ports:
clk  in  1  system clock; all logic rising-edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; begins execution at START_ADDR when idle.
abort  in  1  synchronous abort; returns to IDLE.
busy  out  1  high from the cycle after an accepted start until IDLE is re-entered.
done  out  1  one-cycle pulse on HALT.
error  out  1  sticky; set on illegal opcode, stack fault or timeout; cleared on the next accepted start.
rom_addr  out  10  instruction ROM address.
rom_data  in  18  ROM output, valid one cycle after rom_addr.
ev  in  8  event inputs; already synchronous to clk.
port_id  out  6  datapath register select.
port_data  out  8  datapath write data.
port_wr  out  1  one-cycle write strobe.
pc  out  10  current program counter, for debug.

Behaviour:
- Reset values: busy=0, done=0, error=0, port_wr=0, port_id=0, port_data=0, pc=START_ADDR, rom_addr=START_ADDR; stack pointer=0; loop counter=0; FSM in IDLE. Reset is asynchronous and may occur in any state.
- FSM states: IDLE, FETCH, EXEC, DELAY, WAIT.
- IDLE:
  - start=1 → pc=START_ADDR, clear error, go to FETCH.
  - start while busy is ignored.
- FETCH:
  - rom_addr=pc; go to EXEC next cycle.
  - rom_addr tracks pc combinationally from a registered pc.
- EXEC: decode rom_data; opcode=[17:14]. Instructions take 2 cycles (FETCH+EXEC) unless stated.
  - 0 NOP: pc+1.
  - 1 OUT: port_id=[13:8], port_data=[7:0], port_wr=1 for exactly one cycle (the cycle after EXEC); pc+1.
  - 2 WAIT: sel=[2:0], pol=[3]. Go to WAIT; exit when ev[sel]==pol. If the condition is already true in EXEC, do not enter WAIT; advance.
  - 3 DELAY: n=[13:0]. n=0 behaves as NOP. Otherwise stay in DELAY exactly n cycles, then FETCH pc+1.
  - 4 JUMP: pc=[9:0].
  - 5 CALL: push pc+1 and set pc=[9:0]. Pushing when the stack is full → error.
  - 6 RET: pop into pc. Popping an empty stack → error.
  - 7 LDCNT: loop counter=[13:0]; pc+1.
  - 8 DJNZ: counter=counter−1 (14-bit, wraps 0→16383); jump to [9:0] if the result ≠0, else pc+1.
  - 9 HALT: done=1 for one cycle; go to IDLE.
  - 10–15: illegal → error.
- PC increment wraps 1023→0.
- On any error: set error, go to IDLE, no done pulse, busy deasserts the next cycle.
- abort: in any non-IDLE state, go to IDLE next cycle. No done pulse, no port_wr in that cycle, error unchanged. abort has priority over start and over instruction effects.
- Simultaneous start and abort while IDLE: abort wins, start is dropped.

Optional Feature:
ATRI_SEQ_WAIT_TIMEOUT_EN
- Defined: a 16-bit counter runs while in WAIT. After WAIT_TIMEOUT cycles without the condition, set error and go to IDLE. The counter clears on entry to WAIT.
- Undefined: WAIT blocks indefinitely; the WAIT_TIMEOUT parameter is unused and no counter is synthesised.

Test Plan:
- ROM [0]=OUT port 5 data 0xA3, [1]=HALT; pulse start → exactly one port_wr with port_id=5, port_data=0xA3; done pulses; busy high for 4 cycles.
- [0]=LDCNT 3, [1]=OUT 1/0x01, [2]=DJNZ 1, [3]=HALT → exactly 3 port_wr strobes, then done; loop counter ends at 0.
- [0]=WAIT sel 2 pol 1, [1]=HALT; hold ev[2]=0 for 50 cycles, then set 1 → no done before ev[2] rises; done 2–3 cycles after. With the macro defined and WAIT_TIMEOUT=20, and ev[2] held at 0 → error=1 and IDLE after 20 WAIT cycles, no done.
- Nested CALL beyond STACK_DEPTH=4 (5 calls deep) → error=1, busy=0, no done. A RET at address 0 with an empty stack → error=1. The next start clears error.
- [0]=DELAY 10, [1]=OUT → port_wr exactly 10 cycles later than with DELAY 0. Opcode 0xF at address 0 → error.
- Assert abort during DELAY, and separately rst_n=0 mid-WAIT → IDLE with all outputs at reset values; no done, no port_wr.
